scr1_tcm_portb_arb: RTL
=======================

# scr1_tcm_portb_arb

Two-requester arbiter and sequencer for port B (read/write port) of the TCM dual-port memory. It sits between the core data-memory interface (requester 0) and a secondary bus master such as DMA or debug-system-bus (requester 1) on one side, and the memory's port B on the other. It grants one request per cycle using round-robin arbitration. It generates the word address, byte enables and lane-aligned write data for the memory, and returns one-cycle responses with the read data lane-aligned.

## Interface
- AW, 16, byte-address width; the memory holds 2^AW bytes; word address is AW-1:2
- clk  in  1  single clock; all state is updated on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rN_req  in  1  request valid (N = 0, 1)
- rN_cmd  in  type_scr1_mem_cmd_e  read or write
- rN_width  in  type_scr1_mem_width_e  byte, halfword or word
- rN_addr  in  AW  byte address
- rN_wdata  in  32  write data, right-justified
- rN_req_ack  out  1  request accepted this cycle
- rN_rdata  out  32  read data, right-justified; valid when rN_resp==RDY for a read
- rN_resp  out  type_scr1_mem_resp_e  IDLE, RDY or ERR
- mem_renb  out  1  port B read enable
- mem_wenb  out  1  port B write enable
- mem_webb  out  4  port B byte enables
- mem_addrb  out  AW-2  port B word address
- mem_datab  out  32  port B write data
- mem_qb  in  32  port B read data, registered by the memory, valid the cycle after mem_renb

## Operation
- Arbitration:
  - Only one requester asserts req: it wins.
  - Both assert req: the port not granted most recently wins.
  - last_grant updates only on a grant.
  - Reset value of last_grant is 1, so port 0 wins the first conflict.
- rN_req_ack is combinational from the current-cycle request and grant. The requester holds its request until it sees ack.
- Alignment checks on the granted request (offset = addr[1:0]):
  - word: offset must be 0.
  - halfword: offset[0] must be 0.
  - byte: always legal.
  - A misaligned request is still acked, but it produces no memory access and returns ERR the next cycle.
- Legal write:
  - mem_wenb=1, mem_renb=0.
  - mem_webb = 4'b0001<<off (byte), 4'b0011<<off (halfword), 4'b1111 (word).
  - mem_datab = wdata<<(8*off).
  - mem_addrb = addr[AW-1:2].
- Legal read:
  - mem_renb=1, mem_wenb=0, mem_webb=0.
  - Port B reads are never issued together with a write, so the memory's read-during-write behaviour is irrelevant.
- Response register (captured at grant): vld, port, err, is_rd, off[1:0].
  - Next cycle, the owning port sees RDY or ERR.
  - Read data: rdata = mem_qb>>(8*off), zero-filled at the top. Sign/zero extension is the requester's job.
  - Write responses and ERR responses drive rdata=0.
- A port not receiving a response drives resp=IDLE and rdata=0.
- When no grant is made, all mem_* outputs are 0.

## Timing
- Request-to-response latency is exactly 1 cycle: ack in cycle N, resp in cycle N+1.
- Fully pipelined: a new grant in cycle N+1 may overlap the response of cycle N. Peak throughput is one access per cycle.
- Simultaneous requests: the loser keeps its req asserted and is granted the next cycle, so worst-case wait is 1 cycle.
- Reset state, asynchronous on rst_n low:
  - response register vld=0, last_grant=1.
  - Every rN_resp=IDLE, rN_rdata=0, rN_req_ack=0.
  - All mem_* outputs 0.
- Reset asserted mid-access: the pending response is discarded and is not replayed after reset.
- Outputs are undefined while rst_n is low only in the sense that req_ack is forced 0; no X may propagate to mem_wenb.

## Structure
- Reuse type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e from the existing memory-interface package. This block adds no new typedefs.
- Add the byte-enable and shift helper functions (be_from_width, align_wdata, align_rdata) to that same package so the AHB/AXI bridges can share them.
- One sub-module is natural: scr1_tcm_portb_req_fmt. It is combinational and covers the misalignment check, webb generation and wdata shift for the granted request.
- The arbiter, mux, and response register stay in the top module.

## Test plan
- Port 0 only, word write addr=0x0010 wdata=0xDEADBEEF, then a word read of 0x0010:
  - write cycle: wenb=1, webb=4'b1111, addrb=0x004.
  - read response: RDY, rdata=0xDEADBEEF one cycle after ack.
- Byte write addr=0x0013 wdata=0x000000A5:
  - webb=4'b1000, datab=0xA5000000.
  - A following byte read of 0x0013 returns rdata=0x000000A5.
- Both ports request every cycle for 6 cycles after reset:
  - grants alternate 0,1,0,1,0,1.
  - each response appears on the correct port exactly 1 cycle after its ack.
- Misaligned requests, halfword addr=0x0001 and word addr=0x0002:
  - ack, no mem_renb or mem_wenb, resp=ERR next cycle.
- Back-to-back reads from port 1 at 0x0020 and 0x0024 in consecutive cycles:
  - responses in consecutive cycles with the correct data each.
- rst_n pulsed low in the cycle after a read ack:
  - no RDY is ever delivered for that read.
  - post-reset conflict is granted to port 0.

Source files
------------

// File: rtl/scr1_tcm_portb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_tcm_portb_arb_pkg
//  Description : Memory-interface types shared by the core/bus bridges, plus
//                byte-enable and lane-alignment helpers for 32-bit ports.
//  Revision    : 1.0 - initial release
// ============================================================================
package scr1_tcm_portb_arb_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE = 2'b00,
    SCR1_MEM_RESP_RDY  = 2'b01,
    SCR1_MEM_RESP_ERR  = 2'b10
  } type_scr1_mem_resp_e;

  // Byte lanes touched by an access of the given width at byte offset off.
  function automatic logic [3:0] be_from_width(input type_scr1_mem_width_e width,
                                               input logic [1:0]           off);
    logic [3:0] be;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << off;
      SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << off;
      SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
      default:              be = 4'b0000;
    endcase
    return be;
  endfunction

  // Move right-justified write data onto the lanes selected by off.
  function automatic logic [31:0] align_wdata(input logic [31:0] wdata,
                                              input logic [1:0]  off);
    return wdata << {off, 3'b000};
  endfunction

  // Bring the addressed lanes of a memory word down to bit 0, zero-filled.
  function automatic logic [31:0] align_rdata(input logic [31:0] rdata,
                                              input logic [1:0]  off);
    return rdata >> {off, 3'b000};
  endfunction

endpackage : scr1_tcm_portb_arb_pkg
`default_nettype wire

// File: rtl/scr1_tcm_portb_req_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_tcm_portb_req_fmt
//  Description : Combinational formatter for the granted port-B request:
//                alignment check, byte enables and lane-shifted write data.
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_tcm_portb_req_fmt
  import scr1_tcm_portb_arb_pkg::*;
(
  input  type_scr1_mem_cmd_e   cmd_i,
  input  type_scr1_mem_width_e width_i,
  input  logic [1:0]           off_i,
  input  logic [31:0]          wdata_i,
  output logic                 misalign_o,
  output logic [3:0]           webb_o,
  output logic [31:0]          datab_o
);

  // Alignment rule per width; an unencoded width is treated as an error.
  always_comb begin
    misalign_o = 1'b1;
    case (width_i)
      SCR1_MEM_WIDTH_BYTE:  misalign_o = 1'b0;
      SCR1_MEM_WIDTH_HWORD: misalign_o = off_i[0];
      SCR1_MEM_WIDTH_WORD:  misalign_o = |off_i;
      default:              misalign_o = 1'b1;
    endcase
  end

  // Byte enables and shifted data only matter for writes; reads drive zero.
  always_comb begin
    webb_o  = 4'b0000;
    datab_o = 32'h0;
    if (cmd_i == SCR1_MEM_CMD_WR) begin
      webb_o  = be_from_width(width_i, off_i);
      datab_o = align_wdata(wdata_i, off_i);
    end
  end

endmodule : scr1_tcm_portb_req_fmt
`default_nettype wire

// File: rtl/scr1_tcm_portb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_tcm_portb_arb
//  Description : Round-robin two-requester arbiter and sequencer for TCM
//                port B. One grant per cycle, responses one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_tcm_portb_arb
  import scr1_tcm_portb_arb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Requester 0 (core data memory interface)
  input  logic                 r0_req_i,
  input  type_scr1_mem_cmd_e   r0_cmd_i,
  input  type_scr1_mem_width_e r0_width_i,
  input  logic [AW-1:0]        r0_addr_i,
  input  logic [31:0]          r0_wdata_i,
  output logic                 r0_req_ack_o,
  output logic [31:0]          r0_rdata_o,
  output type_scr1_mem_resp_e  r0_resp_o,
  // Requester 1 (secondary bus master)
  input  logic                 r1_req_i,
  input  type_scr1_mem_cmd_e   r1_cmd_i,
  input  type_scr1_mem_width_e r1_width_i,
  input  logic [AW-1:0]        r1_addr_i,
  input  logic [31:0]          r1_wdata_i,
  output logic                 r1_req_ack_o,
  output logic [31:0]          r1_rdata_o,
  output type_scr1_mem_resp_e  r1_resp_o,
  // Memory port B
  output logic                 mem_renb_o,
  output logic                 mem_wenb_o,
  output logic [3:0]           mem_webb_o,
  output logic [AW-3:0]        mem_addrb_o,
  output logic [31:0]          mem_datab_o,
  input  logic [31:0]          mem_qb_i
);

  // Arbitration and response state
  logic       last_q, last_d;
  logic       vld_q,  vld_d;
  logic       port_q, port_d;
  logic       err_q,  err_d;
  logic       rd_q,   rd_d;
  logic [1:0] off_q,  off_d;

  logic                 w_gnt0, w_gnt1, w_gnt, w_acc;
  type_scr1_mem_cmd_e   w_cmd;
  type_scr1_mem_width_e w_width;
  logic [AW-1:0]        w_addr;
  logic [31:0]          w_wdata;
  logic                 w_misalign;
  logic [3:0]           w_webb;
  logic [31:0]          w_datab;

  // Grant: sole requester wins; on conflict the port not granted last wins.
  // rst_n gates the grant so nothing reaches ack or the memory during reset.
  assign w_gnt0 = rst_n & r0_req_i & (~r1_req_i |  last_q);
  assign w_gnt1 = rst_n & r1_req_i & (~r0_req_i | ~last_q);
  assign w_gnt  = w_gnt0 | w_gnt1;

  assign r0_req_ack_o = w_gnt0;
  assign r1_req_ack_o = w_gnt1;

  // Steer the granted requester's fields to the formatter and memory.
  always_comb begin
    w_cmd   = r0_cmd_i;
    w_width = r0_width_i;
    w_addr  = r0_addr_i;
    w_wdata = r0_wdata_i;
    if (w_gnt1) begin
      w_cmd   = r1_cmd_i;
      w_width = r1_width_i;
      w_addr  = r1_addr_i;
      w_wdata = r1_wdata_i;
    end
  end

  scr1_tcm_portb_req_fmt u_req_fmt (
    .cmd_i      (w_cmd),
    .width_i    (w_width),
    .off_i      (w_addr[1:0]),
    .wdata_i    (w_wdata),
    .misalign_o (w_misalign),
    .webb_o     (w_webb),
    .datab_o    (w_datab)
  );

  // A memory access happens only for a legal granted request.
  assign w_acc = w_gnt & ~w_misalign;

  // Port B drive; everything is zero unless an access is issued.
  always_comb begin
    mem_renb_o  = 1'b0;
    mem_wenb_o  = 1'b0;
    mem_webb_o  = 4'b0000;
    mem_addrb_o = '0;
    mem_datab_o = 32'h0;
    if (w_acc) begin
      mem_renb_o  = (w_cmd == SCR1_MEM_CMD_RD);
      mem_wenb_o  = (w_cmd == SCR1_MEM_CMD_WR);
      mem_webb_o  = w_webb;
      mem_addrb_o = w_addr[AW-1:2];
      mem_datab_o = w_datab;
    end
  end

  // Next-state: response descriptor captured at grant, last_grant on grant.
  always_comb begin
    vld_d  = w_gnt;
    port_d = w_gnt1;
    err_d  = w_gnt & w_misalign;
    rd_d   = (w_cmd == SCR1_MEM_CMD_RD);
    off_d  = w_addr[1:0];
    last_d = w_gnt ? w_gnt1 : last_q;
  end

  // State register; async reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      vld_q  <= 1'b0;
      port_q <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= 1'b0;
      off_q  <= 2'b00;
    end else begin
      last_q <= last_d;
      vld_q  <= vld_d;
      port_q <= port_d;
      err_q  <= err_d;
      rd_q   <= rd_d;
      off_q  <= off_d;
    end
  end

  // Route the response to its owner; read data is lane-aligned to bit 0.
  always_comb begin
    r0_resp_o  = SCR1_MEM_RESP_IDLE;
    r0_rdata_o = 32'h0;
    r1_resp_o  = SCR1_MEM_RESP_IDLE;
    r1_rdata_o = 32'h0;
    if (vld_q) begin
      if (port_q) begin
        r1_resp_o  = err_q ? SCR1_MEM_RESP_ERR : SCR1_MEM_RESP_RDY;
        r1_rdata_o = (!err_q && rd_q) ? align_rdata(mem_qb_i, off_q) : 32'h0;
      end else begin
        r0_resp_o  = err_q ? SCR1_MEM_RESP_ERR : SCR1_MEM_RESP_RDY;
        r0_rdata_o = (!err_q && rd_q) ? align_rdata(mem_qb_i, off_q) : 32'h0;
      end
    end
  end

endmodule : scr1_tcm_portb_arb
`default_nettype wire
